// File: rtl/tetris_pkg.sv
// Shared playfield types and geometry for the Tetris row datapath.
package tetris_pkg;

  localparam int unsigned ROWS      = 22;
  localparam int unsigned COLS      = 12;
  localparam int unsigned ROW_IDX_W = 5;

  typedef logic [COLS-1:0] row_t;

  localparam row_t EMPTY_ROW = 12'h801;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, REARM} collapse_state_t;

endpackage

// File: rtl/row_collapse.sv
// Playfield register array: merges locked pieces and collapses a cleared row one row per clock.
// Optional macro ROW_SCORE_EN enables the score accumulator with a 4-collapse combo bonus.
module row_collapse
  import tetris_pkg::*;
#(
  parameter int unsigned LINE_CNT_W      = 16,
  parameter int unsigned SCORE_W         = 20,
  parameter int unsigned POINTS_PER_LINE = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_req,
  input  logic [ROW_IDX_W-1:0]      clear_row,
  input  logic                      frame_tick,
  input  logic                      lock_valid,
  input  logic [ROW_IDX_W-1:0]      lock_row,
  input  logic [COLS-1:0]           lock_mask,
  output logic                      lock_ready,
  output row_t [ROWS-1:0]           row_contents,
  output logic                      busy,
  output logic                      collapse_done,
  output logic [LINE_CNT_W-1:0]     lines_total,
  output logic [SCORE_W-1:0]        score
);

  collapse_state_t       state, state_next;
  logic [ROW_IDX_W-1:0]  ptr, ptr_next, ptr_m1;
  logic                  do_lock, do_shift, do_empty;
  row_t [ROWS-1:0]       row_q;
  logic [LINE_CNT_W-1:0] lines_q;

  assign ptr_m1       = ptr - ROW_IDX_W'(1);
  assign row_contents = row_q;
  assign lines_total  = lines_q;

  // State, pointer and state-decoded outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ptr           <= '0;
      busy          <= 1'b0;
      lock_ready    <= 1'b1;
      collapse_done <= 1'b0;
    end else begin
      state         <= state_next;
      ptr           <= ptr_next;
      busy          <= (state_next != IDLE);
      lock_ready    <= (state_next == IDLE);
      collapse_done <= (state_next == DONE);
    end
  end

  // Next-state and datapath controls
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    do_lock    = 1'b0;
    do_shift   = 1'b0;
    do_empty   = 1'b0;
    unique case (state)
      IDLE: begin
        if (lock_valid) begin
          do_lock = (lock_row < ROW_IDX_W'(ROWS));
        end else if (clear_req && (clear_row != '0) &&
                     (clear_row <= ROW_IDX_W'(ROWS - 1))) begin
          ptr_next   = clear_row;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (ptr != '0) begin
          do_shift = 1'b1;
          ptr_next = ptr_m1;
        end else begin
          do_empty   = 1'b1;
          state_next = DONE;
        end
      end
      DONE:  state_next = REARM;
      REARM: if (frame_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Playfield storage; wall bits are preserved since rows only OR in or move whole
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= {ROWS{EMPTY_ROW}};
    end else begin
      if (do_lock)  row_q[lock_row] <= row_q[lock_row] | lock_mask;
      if (do_shift) row_q[ptr]      <= row_q[ptr_m1];
      if (do_empty) row_q[0]        <= EMPTY_ROW;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lines_q <= '0;
    end else if ((state == DONE) && (lines_q != '1)) begin
      lines_q <= lines_q + LINE_CNT_W'(1);
    end
  end

`ifdef ROW_SCORE_EN
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W:0]   score_sum_c;
  logic [1:0]         combo_q;
  logic               combo_watch_q;

  assign score_sum_c = {1'b0, score_q} + ((combo_q == 2'd3) ?
                       (SCORE_W+1)'(4 * POINTS_PER_LINE) : (SCORE_W+1)'(POINTS_PER_LINE));

  // Combo breaks when the first frame after re-arm brings no clear request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q       <= '0;
      combo_q       <= '0;
      combo_watch_q <= 1'b0;
    end else if (state == DONE) begin
      score_q       <= score_sum_c[SCORE_W] ? '1 : score_sum_c[SCORE_W-1:0];
      combo_q       <= (combo_q == 2'd3) ? 2'd0 : combo_q + 2'd1;
      combo_watch_q <= 1'b0;
    end else if ((state == REARM) && frame_tick) begin
      combo_watch_q <= 1'b1;
    end else if (state == IDLE) begin
      if (state_next == SHIFT) begin
        combo_watch_q <= 1'b0;
      end else if (combo_watch_q && frame_tick && !clear_req) begin
        combo_q       <= '0;
        combo_watch_q <= 1'b0;
      end
    end
  end

  assign score = score_q;
`else
  assign score = '0;
`endif

endmodule
